// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: per-frame controller that starts the CNN core, forwards one frame of pixels and returns its result
//   clk, rst (async, active-low)
//   frame_req/abort in, frame_ack out        : host frame control
//   s_pix_valid/s_pix_data in, s_pix_ready   : upstream pixel stream
//   cnn_start, cnn_pixel_valid, cnn_pixel    : core drive
//   cnn_result_valid, cnn_result             : core result
//   res_valid/res_data out, res_ready in     : result port
//   busy, timeout_err, frame_count           : status
module cnn_frame_sequencer #(
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int PIX_W       = 8,
  parameter int RES_W       = 48,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_req,
  input  logic             abort,
  output logic             frame_ack,
  input  logic             s_pix_valid,
  input  logic [PIX_W-1:0] s_pix_data,
  output logic             s_pix_ready,
  output logic             cnn_start,
  output logic             cnn_pixel_valid,
  output logic [PIX_W-1:0] cnn_pixel,
  input  logic             cnn_result_valid,
  input  logic [RES_W-1:0] cnn_result,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [15:0]      frame_count
);
  localparam int FRAME = IMG_W * IMG_H;
  localparam int PCW   = $clog2(FRAME + 1);
  localparam int WDW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PCW-1:0] PIX_LAST = PCW'(FRAME - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYC - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_STREAM = 3'd2,
                         S_WAIT = 3'd3, S_HOLD  = 3'd4, S_ERR    = 3'd5;
  logic [2:0]       state_q, state_d;
  logic [PCW-1:0]   pix_q, pix_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             ack_q, ack_d, start_q, start_d, pv_q, pv_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic             rv_q, rv_d, terr_q, terr_d;
  logic [RES_W-1:0] rd_q, rd_d;
  logic [15:0]      fc_q, fc_d;
  logic             beat;
  assign s_pix_ready     = state_q == S_STREAM;
  assign busy            = state_q != S_IDLE;
  assign beat            = s_pix_valid && s_pix_ready;
  assign frame_ack       = ack_q;
  assign cnn_start       = start_q;
  assign cnn_pixel_valid = pv_q;
  assign cnn_pixel       = pixel_q;
  assign res_valid       = rv_q;
  assign res_data        = rd_q;
  assign timeout_err     = terr_q;
  assign frame_count     = fc_q;
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    wd_d    = wd_q;
    ack_d   = 1'b0;
    start_d = 1'b0;
    pv_d    = 1'b0;
    pixel_d = pixel_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    terr_d  = terr_q;
    fc_d    = fc_q;
    case (state_q)
      S_IDLE: if (frame_req && !abort) begin
        state_d = S_START;
        ack_d   = 1'b1;
        start_d = 1'b1;
        terr_d  = 1'b0;
      end
      S_START: begin
        pix_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: if (beat) begin
        pv_d    = 1'b1;
        pixel_d = s_pix_data;
        pix_d   = pix_q + 1'b1;
        wd_d    = '0;
        state_d = pix_q == PIX_LAST ? S_WAIT : S_STREAM;
      end
      // a result arriving on the terminal watchdog count still wins
      S_WAIT: if (cnn_result_valid) begin
        rv_d    = 1'b1;
        rd_d    = cnn_result;
        state_d = S_HOLD;
      end else if (wd_q == WD_LAST) begin
        terr_d  = 1'b1;
        state_d = S_ERR;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      S_HOLD: if (res_ready) begin
        rv_d    = 1'b0;
        fc_d    = fc_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort cancels the frame from any active state, dropping the in-flight beat or pending result
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      pv_d    = 1'b0;
      rv_d    = 1'b0;
      fc_d    = fc_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      wd_q    <= '0;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      pv_q    <= 1'b0;
      pixel_q <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      terr_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      pv_q    <= pv_d;
      pixel_q <= pixel_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      terr_q  <= terr_d;
      fc_q    <= fc_d;
    end
  end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: randomized frame-level checks of cnn_frame_sequencer against a transaction model
module tb_cnn_frame_sequencer;
  localparam int IMG_W = 32, IMG_H = 32, PIX_W = 8, RES_W = 48, TO = 50000;
  localparam int FRAME = IMG_W * IMG_H;
  logic clk = 1'b0, rst = 1'b0;
  logic frame_req = 1'b0, abort = 1'b0, s_pix_valid = 1'b0, cnn_result_valid = 1'b0, res_ready = 1'b0;
  logic [PIX_W-1:0] s_pix_data = '0;
  logic [RES_W-1:0] cnn_result = '0;
  logic frame_ack, s_pix_ready, cnn_start, cnn_pixel_valid, res_valid, busy, timeout_err;
  logic [PIX_W-1:0] cnn_pixel;
  logic [RES_W-1:0] res_data;
  logic [15:0] frame_count;
  int checks = 0, failures = 0;
  logic [15:0] exp_fc = '0;
  cnn_frame_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .RES_W(RES_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .abort(abort), .frame_ack(frame_ack),
    .s_pix_valid(s_pix_valid), .s_pix_data(s_pix_data), .s_pix_ready(s_pix_ready),
    .cnn_start(cnn_start), .cnn_pixel_valid(cnn_pixel_valid), .cnn_pixel(cnn_pixel),
    .cnn_result_valid(cnn_result_valid), .cnn_result(cnn_result),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .timeout_err(timeout_err), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [79:0] all_out();
    return {frame_ack, s_pix_ready, cnn_start, cnn_pixel_valid, cnn_pixel, res_valid,
            res_data, busy, timeout_err, frame_count};
  endfunction
  function automatic logic [PIX_W-1:0] pat(input int i);
    return PIX_W'(100 + ((i % IMG_W) ^ (i / IMG_W)));
  endfunction
  task automatic step();
    @(negedge clk);
  endtask
  // gap: 0 back-to-back pattern, 1 alternating pattern, 2 random valid and data
  // cut_at >= 0 interrupts the frame at that beat with abort (cut_rst=0) or reset (cut_rst=1)
  task automatic run_frame(input int gap, input int cut_at, input bit cut_rst, input int res_delay,
                           input logic [RES_W-1:0] result, input int hold, input bit timeout);
    int sent = 0, cyc = 0, k;
    bit prev = 1'b0, v;
    logic [PIX_W-1:0] pd = '0;
    frame_req = 1'b1;
    step();
    check("ack", frame_ack, 1);
    check("start", cnn_start, 1);
    check("terr_clr", timeout_err, 0);
    check("busy_start", busy, 1);
    check("ready_start", s_pix_ready, 0);
    frame_req = 1'b0;
    step();
    check("ack_pulse", frame_ack, 0);
    check("start_pulse", cnn_start, 0);
    while (sent < FRAME && cyc < 8 * FRAME) begin
      check("ready", s_pix_ready, 1);
      check("pv", cnn_pixel_valid, prev);
      if (prev) check("pix", cnn_pixel, pd);
      v = gap == 0 ? 1'b1 : gap == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      s_pix_valid = v;
      s_pix_data = (v && gap != 2) ? pat(sent) : PIX_W'($urandom);
      if (v && sent == cut_at) begin
        if (cut_rst) begin
          #2 rst = 1'b0;
          #1 check("rst_async", all_out(), 0);
          step();
          step();
          check("rst_hold", all_out(), 0);
          rst = 1'b1;
          s_pix_valid = 1'b0;
          exp_fc = '0;
          step();
          check("rst_idle", all_out(), 0);
          return;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        s_pix_valid = 1'b0;
        check("abort_pv", cnn_pixel_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", s_pix_ready, 0);
        check("abort_rv", res_valid, 0);
        repeat (3) begin
          step();
          check("abort_quiet", cnn_pixel_valid, 0);
          check("abort_fc", frame_count, exp_fc);
        end
        return;
      end
      prev = v;
      pd = s_pix_data;
      if (v) sent++;
      cyc++;
      step();
    end
    check("beats", sent, FRAME);
    check("pv_last", cnn_pixel_valid, 1);
    check("pix_last", cnn_pixel, pd);
    check("ready_drop", s_pix_ready, 0);
    check("busy_wait", busy, 1);
    s_pix_valid = 1'b1;
    step();
    s_pix_valid = 1'b0;
    check("ready_gate", cnn_pixel_valid, 0);
    if (timeout) begin
      k = 1;
      while (!timeout_err && k < TO + 10) begin
        step();
        k++;
      end
      check("timeout_cycles", k, TO);
      check("err_busy", busy, 1);
      check("err_fc", frame_count, exp_fc);
      check("err_rv", res_valid, 0);
      step();
      check("err_idle", busy, 0);
      check("terr_sticky", timeout_err, 1);
      return;
    end
    repeat (res_delay) begin
      step();
      check("wait_rv", res_valid, 0);
      check("wait_busy", busy, 1);
    end
    cnn_result_valid = 1'b1;
    cnn_result = result;
    step();
    cnn_result_valid = 1'b0;
    cnn_result = RES_W'({$urandom, $urandom});
    check("rv", res_valid, 1);
    check("rd", res_data, result);
    for (int i = 0; i < hold; i++) begin
      frame_req = 1'b1;
      if (i == 2) begin
        cnn_result_valid = 1'b1;
        cnn_result = ~result;
      end
      step();
      cnn_result_valid = 1'b0;
      check("hold_rv", res_valid, 1);
      check("hold_rd", res_data, result);
      check("hold_fc", frame_count, exp_fc);
      check("hold_ack", frame_ack, 0);
    end
    frame_req = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_fc++;
    check("done_rv", res_valid, 0);
    check("done_fc", frame_count, exp_fc);
    check("done_busy", busy, 0);
    check("done_rd", res_data, result);
  endtask
  initial begin
    repeat (3) step();
    check("reset", all_out(), 0);
    rst = 1'b1;
    step();
    check("idle", all_out(), 0);
    abort = 1'b1;
    frame_req = 1'b1;
    step();
    check("abort_prio_ack", frame_ack, 0);
    check("abort_prio_busy", busy, 0);
    abort = 1'b0;
    frame_req = 1'b0;
    cnn_result_valid = 1'b1;
    cnn_result = 48'd123;
    step();
    cnn_result_valid = 1'b0;
    check("spurious_rv", res_valid, 0);
    check("spurious_rd", res_data, 0);
    run_frame(0, -1, 1'b0, 5, 48'd68264, 0, 1'b0);
    run_frame(1, -1, 1'b0, 3, RES_W'({$urandom, $urandom}), 2, 1'b0);
    run_frame(0, -1, 1'b0, 1, -48'sd5, 10, 1'b0);
    run_frame(2, -1, 1'b0, 0, '0, 0, 1'b1);
    run_frame(0, 500, 1'b0, 0, '0, 0, 1'b0);
    run_frame(2, -1, 1'b0, $urandom_range(1, 20), RES_W'({$urandom, $urandom}), $urandom_range(0, 5), 1'b0);
    run_frame(0, $urandom_range(50, 900), 1'b1, 0, '0, 0, 1'b0);
    repeat (2) run_frame($urandom_range(0, 2), -1, 1'b0, $urandom_range(1, 30),
                         RES_W'({$urandom, $urandom}), $urandom_range(0, 6), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
